// File: rtl/pmod_audio_pwm_rx.sv
// Fixed-frame PWM audio decoder: measures high time per frame and emits 16-bit PCM samples.
// Optional 3-tap majority glitch filter enabled by defining PMOD_AUDIO_RX_GLITCH_FILTER_EN.
module pmod_audio_pwm_rx #(
    parameter int FRAME_LEN   = 512,
    parameter int SHIFT       = 7,
    parameter int TOL         = 2,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwm_in,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        locked,
    output logic        overrun,
    input  logic        err_clr
);
    localparam int CW = 10;
    localparam int LW = $clog2(LOCK_FRAMES + 1);
    localparam logic [CW-1:0] PER_MIN  = CW'(FRAME_LEN - TOL);
    localparam logic [CW-1:0] PER_MAX  = CW'(FRAME_LEN + TOL);
    localparam logic [CW-1:0] TMO      = CW'(FRAME_LEN + TOL + 1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    // High count to code, clamped to the 16-bit range.
    function automatic logic [15:0] sat_code(input logic [CW-1:0] h);
        logic [CW+SHIFT-1:0] wide;
        logic [15:0]         res;
        wide = {{SHIFT{1'b0}}, h - CW'(1)} << SHIFT;
        if (|wide[CW+SHIFT-1:16]) begin
            res = 16'hFFFF;
        end else begin
            res = wide[15:0];
        end
        return res;
    endfunction

    logic          sync1_r;
    logic          sync2_r;
    logic          s_s;
    logic          s_d_r;
    logic          rise_r;
    logic          fall_r;
    state_t        state_r;
    logic [CW-1:0] hcnt_r;
    logic [CW-1:0] pcnt_r;
    logic [LW-1:0] lock_cnt_r;
    logic [15:0]   sample_r;
    logic          valid_r;
    logic          locked_r;
    logic          overrun_r;
    logic          good_s;
    logic          timeout_s;
    logic [LW-1:0] lock_inc_s;
    logic [15:0]   code_s;

    // Two-flop synchroniser for the asynchronous PWM input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= pwm_in;
            sync2_r <= sync1_r;
        end
    end

`ifdef PMOD_AUDIO_RX_GLITCH_FILTER_EN
    logic tap1_r;
    logic tap2_r;
    logic filt_r;

    // Majority of three consecutive samples; single-cycle pulses never win the vote.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap1_r <= 1'b0;
            tap2_r <= 1'b0;
            filt_r <= 1'b0;
        end else begin
            tap1_r <= sync2_r;
            tap2_r <= tap1_r;
            filt_r <= (sync2_r & tap1_r) | (sync2_r & tap2_r) | (tap1_r & tap2_r);
        end
    end

    assign s_s = filt_r;
`else
    assign s_s = sync2_r;
`endif

    // Registered rise/fall strobes on the cleaned stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_d_r  <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            s_d_r  <= s_s;
            rise_r <= s_s & ~s_d_r;
            fall_r <= ~s_s & s_d_r;
        end
    end

    // Frame evaluation terms derived from the current counters.
    always_comb begin
        good_s    = (pcnt_r >= PER_MIN) && (pcnt_r <= PER_MAX);
        timeout_s = (hcnt_r >= TMO) || (pcnt_r >= TMO);
        code_s    = sat_code(hcnt_r);
        if (lock_cnt_r == LOCK_MAX) begin
            lock_inc_s = lock_cnt_r;
        end else begin
            lock_inc_s = lock_cnt_r + LW'(1);
        end
    end

    // Frame FSM, lock tracking and the sample handshake with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_HUNT;
            hcnt_r     <= '0;
            pcnt_r     <= '0;
            lock_cnt_r <= '0;
            sample_r   <= 16'h0000;
            valid_r    <= 1'b0;
            locked_r   <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            if (err_clr) begin
                overrun_r <= 1'b0;
            end
            if (valid_r && sample_ready) begin
                valid_r <= 1'b0;
            end
            case (state_r)
                ST_HUNT: begin
                    if (rise_r) begin
                        state_r <= ST_HIGH;
                        hcnt_r  <= CW'(1);
                        pcnt_r  <= CW'(1);
                    end
                end
                ST_HIGH: begin
                    if (timeout_s) begin
                        state_r    <= ST_HUNT;
                        hcnt_r     <= '0;
                        pcnt_r     <= '0;
                        lock_cnt_r <= '0;
                        locked_r   <= 1'b0;
                    end else begin
                        pcnt_r <= pcnt_r + CW'(1);
                        if (fall_r) begin
                            state_r <= ST_LOW;
                        end else begin
                            hcnt_r <= hcnt_r + CW'(1);
                        end
                    end
                end
                ST_LOW: begin
                    if (timeout_s) begin
                        state_r    <= ST_HUNT;
                        hcnt_r     <= '0;
                        pcnt_r     <= '0;
                        lock_cnt_r <= '0;
                        locked_r   <= 1'b0;
                    end else if (rise_r) begin
                        state_r <= ST_HIGH;
                        hcnt_r  <= CW'(1);
                        pcnt_r  <= CW'(1);
                        if (good_s) begin
                            lock_cnt_r <= lock_inc_s;
                            locked_r   <= (lock_inc_s == LOCK_MAX);
                            if (lock_inc_s == LOCK_MAX) begin
                                // A fresh sample always wins over a same-cycle accept.
                                sample_r <= code_s;
                                valid_r  <= 1'b1;
                                if (valid_r && !sample_ready) begin
                                    overrun_r <= 1'b1;
                                end
                            end
                        end else begin
                            lock_cnt_r <= '0;
                            locked_r   <= 1'b0;
                        end
                    end else begin
                        pcnt_r <= pcnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r    <= ST_HUNT;
                    hcnt_r     <= '0;
                    pcnt_r     <= '0;
                    lock_cnt_r <= '0;
                    locked_r   <= 1'b0;
                end
            endcase
        end
    end

    assign sample_out   = sample_r;
    assign sample_valid = valid_r;
    assign locked       = locked_r;
    assign overrun      = overrun_r;

endmodule

// File: tb/tb_pmod_audio_pwm_rx.sv
// Self-checking bench for pmod_audio_pwm_rx: directed tables, corner sequences and a random stream
// compared against a frame-level reference model.
module tb_pmod_audio_pwm_rx;
    localparam int FRAME = 512;
    localparam int TOLP  = 2;
    localparam int LOCKN = 2;
`ifdef PMOD_AUDIO_RX_GLITCH_FILTER_EN
    localparam int LAT  = 5;
    localparam int MINW = 2;
`else
    localparam int LAT  = 3;
    localparam int MINW = 1;
`endif

    typedef struct {
        logic [15:0] src;
        logic [15:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pwm_in = 1'b0;
    logic        sample_ready = 1'b1;
    logic        err_clr = 1'b0;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        locked;
    logic        overrun;

    int          n_cmp = 0;
    int          n_err = 0;
    logic        mon_en = 1'b0;
    logic [15:0] got_q[$];
    int          dp[$];
    int          dh[$];
    int          mp[$];
    int          mh[$];
    vec_t        vt[$];

    always #5 clk = ~clk;

    pmod_audio_pwm_rx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pwm_in       (pwm_in),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .locked       (locked),
        .overrun      (overrun),
        .err_clr      (err_clr)
    );

    // Collect every accepted sample.
    always @(negedge clk) begin
        if (mon_en && sample_valid && sample_ready) got_q.push_back(sample_out);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transmitter model: high time for a 16-bit source sample.
    function automatic int tx_high(input logic [15:0] src);
        int h;
        h = (int'(src) + 127) >> 7;
        if (h < 1) h = 1;
        if (h > 511) h = 511;
        return h;
    endfunction

    function automatic logic [15:0] exp_code(input int h);
        longint v;
        v = longint'(h - 1) * 128;
        if (v > 65535) v = 65535;
        return 16'(v);
    endfunction

    task automatic send_frame(input int p, input int h);
        for (int i = 0; i < p; i++) begin
            pwm_in = (i < h) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
    endtask

    // Closing rise, then stuck low long enough to time out back to hunting.
    task automatic send_close();
        for (int i = 0; i < 540; i++) begin
            pwm_in = (i < 4) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pwm_in = i[0];
            @(negedge clk);
        end
        chk("reset sample_out", 32'(sample_out), 32'h0);
        chk("reset sample_valid", 32'(sample_valid), 32'h0);
        chk("reset locked", 32'(locked), 32'h0);
        chk("reset overrun", 32'(overrun), 32'h0);
        pwm_in = 1'b0;
        rst_n  = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    // Drive dp/dh, then compare accepted samples with the model run over mp/mh.
    task automatic run_stream(input string name);
        logic [15:0] exp_q[$];
        int lk = 0;
        got_q.delete();
        mon_en = 1'b1;
        foreach (dp[i]) send_frame(dp[i], dh[i]);
        send_close();
        mon_en = 1'b0;
        foreach (mp[i]) begin
            if (mp[i] >= FRAME - TOLP && mp[i] <= FRAME + TOLP) begin
                lk = (lk < LOCKN) ? lk + 1 : LOCKN;
                if (lk == LOCKN) exp_q.push_back(exp_code(mh[i]));
            end else begin
                lk = 0;
            end
        end
        chk({name, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({name, " sample"}, 32'(got_q[i]), 32'(exp_q[i]));
        chk({name, " locked after stuck low"}, 32'(locked), 32'h0);
    endtask

    task automatic clear_lists();
        dp.delete(); dh.delete(); mp.delete(); mh.delete();
    endtask

    initial begin
`ifndef PMOD_AUDIO_RX_GLITCH_FILTER_EN
        vt.push_back('{16'h0000, 16'h0000});
`endif
        vt.push_back('{16'hFFFF, 16'hFF00});
        vt.push_back('{16'h0081, 16'h0080});
        vt.push_back('{16'h8000, 16'h7F80});
        vt.push_back('{16'h4000, 16'h3F80});
        vt.push_back('{16'h1234, 16'h1200});

        // Lock timing and first-sample latency.
        do_reset();
        send_frame(512, 256);
        send_frame(512, 256);
        fork
            send_frame(512, 256);
            begin
                @(posedge clk);
                repeat (LAT - 1) @(posedge clk);
                #1;
                chk("latency valid early", 32'(sample_valid), 32'h0);
                chk("latency locked early", 32'(locked), 32'h0);
                @(posedge clk);
                #1;
                chk("latency valid", 32'(sample_valid), 32'h1);
                chk("latency locked", 32'(locked), 32'h1);
                chk("latency sample", 32'(sample_out), 32'h7F80);
            end
        join

        // Reset in the middle of a frame drops a pending sample.
        sample_ready = 1'b0;
        pwm_in = 1'b1;
        repeat (60) @(negedge clk);
        chk("pending valid", 32'(sample_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midframe rst valid", 32'(sample_valid), 32'h0);
        chk("midframe rst sample", 32'(sample_out), 32'h0);
        chk("midframe rst locked", 32'(locked), 32'h0);
        sample_ready = 1'b1;
        pwm_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Decode table.
        foreach (vt[i]) begin
            do_reset();
            clear_lists();
            for (int k = 0; k < 4; k++) begin
                dp.push_back(512); dh.push_back(tx_high(vt[i].src));
                mp.push_back(512); mh.push_back(tx_high(vt[i].src));
            end
            run_stream("decode table");
            chk("decode table n", 32'(got_q.size()), 32'd3);
            foreach (got_q[k]) chk("decode table value", 32'(got_q[k]), 32'(vt[i].exp));
        end

        // Backpressure and overrun.
        do_reset();
        sample_ready = 1'b0;
        send_frame(512, tx_high(16'h8000));
        send_frame(512, tx_high(16'h1234));
        send_frame(512, tx_high(16'h8000));
        chk("bp valid 1", 32'(sample_valid), 32'h1);
        chk("bp sample 1", 32'(sample_out), 32'h1200);
        chk("bp overrun 0", 32'(overrun), 32'h0);
        send_frame(512, tx_high(16'hFFFF));
        chk("bp sample 2", 32'(sample_out), 32'h7F80);
        chk("bp overrun 1", 32'(overrun), 32'h1);
        send_close();
        chk("bp sample 3", 32'(sample_out), 32'hFF00);
        chk("bp valid held", 32'(sample_valid), 32'h1);
        chk("bp overrun sticky", 32'(overrun), 32'h1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr overrun", 32'(overrun), 32'h0);
        chk("err_clr valid", 32'(sample_valid), 32'h1);
        sample_ready = 1'b1;
        @(negedge clk);
        chk("accept drops valid", 32'(sample_valid), 32'h0);

        // Bad period then relock.
        do_reset();
        clear_lists();
        dp = '{512, 512, 512, 600, 512, 512, 512};
        dh = '{256, 256, 256, 256, 256, 256, 256};
        mp = dp; mh = dh;
        run_stream("bad period");

        // One-cycle glitch at cycle 300 of a frame.
        do_reset();
        clear_lists();
        dp = '{512, 512, 512, 300, 212, 512, 512};
        dh = '{100, 100, 100, 100, 1, 100, 100};
`ifdef PMOD_AUDIO_RX_GLITCH_FILTER_EN
        mp = '{512, 512, 512, 512, 512, 512};
        mh = '{100, 100, 100, 100, 100, 100};
`else
        mp = dp; mh = dh;
`endif
        run_stream("glitch");

        // Random stream including tolerance edges, bad periods and saturation.
        do_reset();
        clear_lists();
        for (int i = 0; i < 24; i++) begin
            int p;
            int h;
            int alt[6] = '{510, 511, 513, 514, 505, 520};
            p = ($urandom_range(0, 9) < 6) ? 512 : alt[$urandom_range(0, 5)];
            h = $urandom_range(MINW, p - MINW);
            dp.push_back(p); dh.push_back(h);
        end
        dp.push_back(512); dh.push_back(200);
        dp.push_back(512); dh.push_back(300);
        dp.push_back(514); dh.push_back(514 - MINW);
        dp.push_back(512); dh.push_back(2);
        mp = dp; mh = dh;
        run_stream("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
